// File: rtl/flash_cache_loader_pkg.sv
// rtl/flash_cache_loader_pkg.sv - state encoding and SPI framing constants for the flash-to-cache loader
package flash_cache_loader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_STARTUP = 3'd0;
   localparam state_t S_CMD     = 3'd1;
   localparam state_t S_ADDR    = 3'd2;
   localparam state_t S_READ    = 3'd3;
   localparam state_t S_WRITE   = 3'd4;
   localparam state_t S_WAIT    = 3'd5;
   localparam state_t S_DONE    = 3'd6;

   localparam logic [7:0] FLASH_CMD_READ = 8'h03;
   localparam int         CMD_ADDR_BITS  = 32;

   // Byte idx of the command+address frame, idx 0 being the command byte (sent first).
   function automatic logic [7:0] cmd_addr_byte(input logic [31:0] frame, input logic [1:0] idx);
      return frame[{~idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/flash_cache_loader_if.sv
// rtl/flash_cache_loader_if.sv - SPI flash pins and cache write port bundled for the loader
interface flash_cache_loader_if;

   logic        flash_clk;
   logic        flash_mosi;
   logic        flash_miso;
   logic        flash_cs;
   logic [31:0] cache_address;
   logic [31:0] cache_data_in;
   logic [3:0]  cache_write_enable;
   logic        cache_busy;

   modport master (
      output flash_clk, flash_mosi, flash_cs,
      output cache_address, cache_data_in, cache_write_enable,
      input  flash_miso, cache_busy
   );

   modport slave (
      input  flash_clk, flash_mosi, flash_cs,
      input  cache_address, cache_data_in, cache_write_enable,
      output flash_miso, cache_busy
   );

endinterface

// File: rtl/flash_spi_shifter.sv
// rtl/flash_spi_shifter.sv - mode-0 SPI byte engine: shifts tx_byte out MSB first while capturing rx_byte
module flash_spi_shifter #(
   parameter int SPI_HALF_PERIOD = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_byte,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);

   localparam logic [15:0] HP_LAST = 16'(SPI_HALF_PERIOD - 1);

   logic [15:0] hp_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  tx_sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         rx_byte <= 8'h00;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         hp_cnt  <= 16'd0;
         bit_cnt <= 3'd0;
         tx_sr   <= 8'h00;
      end else begin
         done <= 1'b0;
         if (!busy) begin
            if (start) begin
               busy    <= 1'b1;
               sclk    <= 1'b0;
               mosi    <= tx_byte[7];
               tx_sr   <= {tx_byte[6:0], 1'b0};
               hp_cnt  <= 16'd0;
               bit_cnt <= 3'd0;
            end
         end else if (hp_cnt != HP_LAST) begin
            hp_cnt <= hp_cnt + 16'd1;
         end else begin
            hp_cnt <= 16'd0;
            if (!sclk) begin
               // miso is captured on the edge that raises sclk
               sclk    <= 1'b1;
               rx_byte <= {rx_byte[6:0], miso};
            end else begin
               sclk <= 1'b0;
               if (bit_cnt == 3'd7) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  mosi <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  mosi    <= tx_sr[7];
                  tx_sr   <= {tx_sr[6:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: rtl/flash_cache_loader.sv
// rtl/flash_cache_loader.sv - boot copier streaming SPI NOR (READ 0x03) into the cache one word at a time
// FLASH_CACHE_LOADER_CHECKSUM_EN adds a running 32-bit sum of written words on port checksum.
module flash_cache_loader #(
   parameter int          STARTUP_WAIT     = 1_000_000,
   parameter logic [23:0] FLASH_START_ADDR = 24'h000000,
   parameter logic [31:0] CACHE_START_ADDR = 32'h0000_0000,
   parameter logic [31:0] TRANSFER_BYTES   = 32'h0020_0000,
   parameter int          SPI_HALF_PERIOD  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   flash_cache_loader_if.master fl_bus,
`ifdef FLASH_CACHE_LOADER_CHECKSUM_EN
   output logic [31:0]          checksum,
`endif
   output logic                 done
);

   import flash_cache_loader_pkg::*;

   localparam logic [31:0] CMD_ADDR_FRAME = {FLASH_CMD_READ, FLASH_START_ADDR};
   localparam logic [4:0]  LAST_HDR_BIT   = 5'(CMD_ADDR_BITS - 8);

   state_t      state;
   logic [31:0] wait_cnt;
   logic [31:0] byte_cnt;
   logic [31:0] word;
   logic [4:0]  bit_cnt;
   logic [1:0]  byte_idx;
   logic        wait_armed;

   logic        shift_start;
   logic        shift_busy;
   logic        shift_done;
   logic [7:0]  shift_tx;
   logic [7:0]  shift_rx;

   // A new byte is launched only once the previous one's done pulse has been consumed.
   always_comb begin
      shift_start = 1'b0;
      shift_tx    = 8'h00;
      if (state == S_CMD || state == S_ADDR)
         shift_tx = cmd_addr_byte(CMD_ADDR_FRAME, bit_cnt[4:3]);
      if ((state == S_CMD || state == S_ADDR || state == S_READ) && !shift_busy && !shift_done)
         shift_start = 1'b1;
   end

   flash_spi_shifter #(
      .SPI_HALF_PERIOD (SPI_HALF_PERIOD)
   ) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .start   (shift_start),
      .tx_byte (shift_tx),
      .busy    (shift_busy),
      .done    (shift_done),
      .rx_byte (shift_rx),
      .sclk    (fl_bus.flash_clk),
      .mosi    (fl_bus.flash_mosi),
      .miso    (fl_bus.flash_miso)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state                     <= S_STARTUP;
         wait_cnt                  <= 32'd0;
         byte_cnt                  <= 32'd0;
         word                      <= 32'd0;
         bit_cnt                   <= 5'd0;
         byte_idx                  <= 2'd0;
         wait_armed                <= 1'b0;
         fl_bus.flash_cs           <= 1'b1;
         fl_bus.cache_address      <= CACHE_START_ADDR;
         fl_bus.cache_data_in      <= 32'd0;
         fl_bus.cache_write_enable <= 4'b0000;
         done                      <= 1'b0;
`ifdef FLASH_CACHE_LOADER_CHECKSUM_EN
         checksum                  <= 32'd0;
`endif
      end else begin
         case (state)
            S_STARTUP: begin
               if (wait_cnt == 32'(STARTUP_WAIT)) begin
                  fl_bus.flash_cs <= 1'b0;
                  state           <= S_CMD;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            S_CMD, S_ADDR: begin
               if (shift_done) begin
                  bit_cnt <= bit_cnt + 5'd8;
                  state   <= (bit_cnt == LAST_HDR_BIT) ? S_READ : S_ADDR;
               end
            end
            S_READ: begin
               if (shift_done) begin
                  word[{byte_idx, 3'b000} +: 8] <= shift_rx;
                  byte_idx                      <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3)
                     state <= S_WRITE;
               end
            end
            S_WRITE: begin
               fl_bus.cache_data_in      <= word;
               fl_bus.cache_write_enable <= 4'b1111;
               wait_armed                <= 1'b1;
               state                     <= S_WAIT;
            end
            S_WAIT: begin
               // cache_busy is not yet meaningful in the cycle right after the write is issued
               if (wait_armed) begin
                  wait_armed <= 1'b0;
               end else if (!fl_bus.cache_busy) begin
                  fl_bus.cache_write_enable <= 4'b0000;
                  fl_bus.cache_address      <= fl_bus.cache_address + 32'd4;
                  byte_cnt                  <= byte_cnt + 32'd4;
`ifdef FLASH_CACHE_LOADER_CHECKSUM_EN
                  checksum                  <= checksum + fl_bus.cache_data_in;
`endif
                  if (byte_cnt + 32'd4 == TRANSFER_BYTES) begin
                     fl_bus.flash_cs <= 1'b1;
                     done            <= 1'b1;
                     state           <= S_DONE;
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_DONE: begin
               fl_bus.flash_cs <= 1'b1;
               done            <= 1'b1;
            end
            default: state <= S_STARTUP;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_cache_loader.sv
// tb/tb_flash_cache_loader.sv - self-checking bench with SPI NOR flash and cache models
module tb_flash_cache_loader;

   localparam int          STARTUP_WAIT     = 10;
   localparam logic [23:0] FLASH_START_ADDR = 24'h000100;
   localparam logic [31:0] CACHE_START_ADDR = 32'hFFFF_FFF8;
   localparam logic [31:0] TRANSFER_BYTES   = 32'd16;
   localparam int          SPI_HALF_PERIOD  = 2;
   localparam int          NW               = 4;
   localparam int          RUN_BUDGET       = 5000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic done;
`ifdef FLASH_CACHE_LOADER_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   always #5 clk = ~clk;

   flash_cache_loader_if fl_bus();

   flash_cache_loader #(
      .STARTUP_WAIT     (STARTUP_WAIT),
      .FLASH_START_ADDR (FLASH_START_ADDR),
      .CACHE_START_ADDR (CACHE_START_ADDR),
      .TRANSFER_BYTES   (TRANSFER_BYTES),
      .SPI_HALF_PERIOD  (SPI_HALF_PERIOD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .fl_bus   (fl_bus),
`ifdef FLASH_CACHE_LOADER_CHECKSUM_EN
      .checksum (checksum),
`endif
      .done     (done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Flash image, index 0 = byte at FLASH_START_ADDR.
   logic [7:0] img [0:255];

   function automatic logic [31:0] exp_word(input int i);
      return {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
   endfunction

   // SPI NOR model: latch 32 header bits on rising edges, shift data out on falling edges.
   int          rise_cnt   = 0;
   int          sclk_edges = 0;
   int          frame_viol = 0;
   logic [31:0] frame_sr   = 32'd0;
   logic [31:0] frame_hdr  = 32'd0;

   always @(posedge fl_bus.flash_cs) rise_cnt = 0;

   always @(posedge fl_bus.flash_clk) begin
      sclk_edges++;
      if (fl_bus.flash_cs !== 1'b0) begin
         frame_viol++;
      end else begin
         if (rise_cnt < 32)
            frame_sr = {frame_sr[30:0], fl_bus.flash_mosi};
         else if (fl_bus.flash_mosi !== 1'b0)
            frame_viol++;
         rise_cnt++;
         if (rise_cnt == 32)
            frame_hdr = frame_sr;
      end
   end

   always @(negedge fl_bus.flash_clk) begin : flash_out
      int         b;
      logic [7:0] idx;
      logic [7:0] cur;
      if (fl_bus.flash_cs === 1'b0 && rise_cnt >= 32) begin
         b   = rise_cnt - 32;
         idx = 8'(frame_hdr[7:0] - FLASH_START_ADDR[7:0] + 8'(b / 8));
         cur = img[idx];
         fl_bus.flash_miso = cur[7 - (b % 8)];
      end
   end

   // Cache model: busy held for hold_cur cycles after issue; busy is random noise when idle.
   int          wi          = 0;
   int          pend        = 0;
   int          hold_left   = 0;
   int          hold_cur    = 0;
   int          h_mode      = 0;
   int          stable_viol = 0;
   int          issue_edges = 0;
   logic        prev_we     = 1'b0;
   logic [31:0] lat_addr    = 32'd0;
   logic [31:0] lat_data    = 32'd0;

   always @(negedge clk) begin
      if (rst) begin
         prev_we           = 1'b0;
         wi                = 0;
         pend              = 0;
         hold_left         = 0;
         fl_bus.cache_busy = 1'b0;
      end else if (fl_bus.cache_write_enable != 4'd0) begin
         if (!prev_we) begin
            check_eq("we_issue", 32'(fl_bus.cache_write_enable), 32'hF);
            check_eq("wr_addr", fl_bus.cache_address, CACHE_START_ADDR + 32'(4 * wi));
            check_eq("wr_data", fl_bus.cache_data_in, exp_word(wi));
            lat_addr    = fl_bus.cache_address;
            lat_data    = fl_bus.cache_data_in;
            pend        = 0;
            issue_edges = sclk_edges;
            hold_cur    = (h_mode < 0) ? int'($urandom_range(0, 10)) : h_mode;
            hold_left   = hold_cur;
         end else if (fl_bus.cache_address !== lat_addr || fl_bus.cache_data_in !== lat_data) begin
            stable_viol++;
         end
         pend++;
         fl_bus.cache_busy = (hold_left > 0);
         if (hold_left > 0)
            hold_left--;
         prev_we = 1'b1;
      end else begin
         if (prev_we) begin
            check_eq("wr_cycles", 32'(pend), 32'((hold_cur + 1 > 2) ? hold_cur + 1 : 2));
            check_eq("sclk_in_write", 32'(sclk_edges - issue_edges), 32'd0);
            check_eq("addr_step", fl_bus.cache_address, lat_addr + 32'd4);
            wi++;
         end
         prev_we           = 1'b0;
         fl_bus.cache_busy = 1'($urandom_range(0, 1));
      end
   end

   task automatic fill_ascending();
      for (int i = 0; i < 256; i++) img[i] = 8'h61 + 8'(i);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_flash_clk", 32'(fl_bus.flash_clk), 32'd0);
      check_eq("rst_mosi", 32'(fl_bus.flash_mosi), 32'd0);
      check_eq("rst_cs", 32'(fl_bus.flash_cs), 32'd1);
      check_eq("rst_addr", fl_bus.cache_address, CACHE_START_ADDR);
      check_eq("rst_data", fl_bus.cache_data_in, 32'd0);
      check_eq("rst_we", 32'(fl_bus.cache_write_enable), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
`ifdef FLASH_CACHE_LOADER_CHECKSUM_EN
      check_eq("rst_checksum", checksum, 32'd0);
`endif
      frame_viol  = 0;
      stable_viol = 0;
      frame_hdr   = 32'd0;
      rst = 1'b0;
   endtask

   task automatic finish_run();
      int          cyc = 0;
      int          edges;
      logic [31:0] sum = 32'd0;
      while (done !== 1'b1 && cyc < RUN_BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      check_eq("done_reached", 32'(done), 32'd1);
      check_eq("frame_hdr", frame_hdr, {8'h03, FLASH_START_ADDR});
      check_eq("write_count", 32'(wi), 32'(NW));
      check_eq("frame_viol", 32'(frame_viol), 32'd0);
      check_eq("stable_viol", 32'(stable_viol), 32'd0);
      check_eq("cs_at_done", 32'(fl_bus.flash_cs), 32'd1);
`ifdef FLASH_CACHE_LOADER_CHECKSUM_EN
      for (int i = 0; i < NW; i++) sum = sum + exp_word(i);
      check_eq("checksum", checksum, sum);
`endif
      edges = sclk_edges;
      repeat (20) @(negedge clk);
      check_eq("sclk_after_done", 32'(sclk_edges - edges), 32'd0);
      check_eq("done_held", 32'(done), 32'd1);
      check_eq("flash_clk_idle", 32'(fl_bus.flash_clk), 32'd0);
   endtask

   initial begin : main
      int cyc;
      fl_bus.flash_miso = 1'b0;
      fl_bus.cache_busy = 1'b0;

      fill_ascending();
      h_mode = 0;
      apply_reset();
      finish_run();

      fill_random();
      h_mode = 10;
      apply_reset();
      finish_run();

      // reset while the second data byte of the first word is being clocked in
      fill_ascending();
      h_mode = -1;
      apply_reset();
      cyc = 0;
      while (rise_cnt < 42 && cyc < RUN_BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("reached_byte2", 32'(rise_cnt >= 42), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_cs", 32'(fl_bus.flash_cs), 32'd1);
      check_eq("abort_we", 32'(fl_bus.cache_write_enable), 32'd0);
      check_eq("abort_done", 32'(done), 32'd0);
      check_eq("abort_sclk", 32'(fl_bus.flash_clk), 32'd0);
      apply_reset();
      finish_run();

      // words FFFFFFFF and 00000002 sum to 00000001
      for (int i = 0; i < 256; i++) img[i] = 8'h00;
      for (int i = 0; i < 4; i++) img[i] = 8'hFF;
      img[4] = 8'h02;
      h_mode = -1;
      apply_reset();
      finish_run();

      for (int r = 0; r < 3; r++) begin
         fill_random();
         h_mode = -1;
         apply_reset();
         finish_run();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
